// File: rtl/dotp_pkg.sv
// Shared types and fixed widths for the dot-product sequencer slice.
package dotp_pkg;

    localparam int unsigned N_ELEM = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RES_W  = 64;

    typedef enum logic [1:0] {
        S_FILL,
        S_START,
        S_WAIT,
        S_OUT
    } seq_state_t;

endpackage

// File: rtl/dotp_operand_buf.sv
// Operand register file: N_ELEM a/b slots filled in order by an internal write index,
// presented packed (slot 0 in the low bits) to the accelerator.
module dotp_operand_buf
    import dotp_pkg::*;
#(
    parameter int unsigned N_ELEM_P = N_ELEM,
    parameter int unsigned DATA_W_P = DATA_W,
    parameter int unsigned IDX_W    = $clog2(N_ELEM_P)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en_i,
    input  logic                         clr_idx_i,
    input  logic [DATA_W_P-1:0]          a_i,
    input  logic [DATA_W_P-1:0]          b_i,
    output logic [IDX_W-1:0]             idx_o,
    output logic                         last_o,
    output logic [N_ELEM_P*DATA_W_P-1:0] acc_a_o,
    output logic [N_ELEM_P*DATA_W_P-1:0] acc_b_o
);

    logic [DATA_W_P-1:0] a_q [N_ELEM_P];
    logic [DATA_W_P-1:0] b_q [N_ELEM_P];
    logic [IDX_W-1:0]    idx_q;

    assign idx_o  = idx_q;
    assign last_o = (idx_q == IDX_W'(N_ELEM_P - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            for (int unsigned i = 0; i < N_ELEM_P; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else if (clr_idx_i) begin
            idx_q <= '0;
        end else if (wr_en_i) begin
            a_q[idx_q] <= a_i;
            b_q[idx_q] <= b_i;
            idx_q      <= last_o ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        acc_a_o = '0;
        acc_b_o = '0;
        for (int unsigned i = 0; i < N_ELEM_P; i++) begin
            acc_a_o[i*DATA_W_P +: DATA_W_P] = a_q[i];
            acc_b_o[i*DATA_W_P +: DATA_W_P] = b_q[i];
        end
    end

endmodule

// File: rtl/dot_product_sequencer.sv
// Initiator for the 8-element dot-product accelerator start/done protocol.
// Optional S_WAIT watchdog enabled by defining DOTSEQ_TIMEOUT_EN.
module dot_product_sequencer
    import dotp_pkg::*;
#(
    parameter int unsigned N_ELEM      = dotp_pkg::N_ELEM,
    parameter int unsigned DATA_W      = dotp_pkg::DATA_W,
    parameter int unsigned RES_W       = dotp_pkg::RES_W,
    parameter int unsigned TAG_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_a,
    input  logic [DATA_W-1:0]        in_b,
    output logic [N_ELEM*DATA_W-1:0] acc_a,
    output logic [N_ELEM*DATA_W-1:0] acc_b,
    output logic                     acc_start,
    input  logic                     acc_done,
    input  logic [RES_W-1:0]         acc_result,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [RES_W-1:0]         res_data,
    output logic [TAG_W-1:0]         res_tag,
    output logic                     busy,
    output logic                     err_timeout
);

    localparam int unsigned IDX_W = $clog2(N_ELEM);

    if (N_ELEM != 8) begin : g_bad_n_elem
        $error("dot_product_sequencer: N_ELEM must be 8 to match the accelerator");
    end
    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("dot_product_sequencer: TIMEOUT_CYC must be non-zero");
    end

    seq_state_t       state_q, state_d;
    logic [RES_W-1:0] res_data_q, res_data_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic [TAG_W-1:0] job_cnt_q, job_cnt_d;
    logic             buf_wr, buf_clr, buf_last;
    logic [IDX_W-1:0] buf_idx;

`ifdef DOTSEQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            err_q, err_d;
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    dotp_operand_buf #(
        .N_ELEM_P (N_ELEM),
        .DATA_W_P (DATA_W),
        .IDX_W    (IDX_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (buf_wr),
        .clr_idx_i (buf_clr),
        .a_i       (in_a),
        .b_i       (in_b),
        .idx_o     (buf_idx),
        .last_o    (buf_last),
        .acc_a_o   (acc_a),
        .acc_b_o   (acc_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FILL;
            res_data_q <= '0;
            res_tag_q  <= '0;
            job_cnt_q  <= '0;
`ifdef DOTSEQ_TIMEOUT_EN
            wdog_q     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            res_data_q <= res_data_d;
            res_tag_q  <= res_tag_d;
            job_cnt_q  <= job_cnt_d;
`ifdef DOTSEQ_TIMEOUT_EN
            wdog_q     <= wdog_d;
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        res_data_d = res_data_q;
        res_tag_d  = res_tag_q;
        job_cnt_d  = job_cnt_q;
        buf_wr     = 1'b0;
        buf_clr    = 1'b0;
        in_ready   = 1'b0;
        acc_start  = 1'b0;
        res_valid  = 1'b0;
`ifdef DOTSEQ_TIMEOUT_EN
        wdog_d     = wdog_q;
        err_d      = err_q;
`endif
        unique case (state_q)
            S_FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    buf_wr = 1'b1;
                    if (buf_last) state_d = S_START;
                end
            end
            S_START: begin
                acc_start = 1'b1;
                state_d   = S_WAIT;
`ifdef DOTSEQ_TIMEOUT_EN
                wdog_d    = '0;
`endif
            end
            S_WAIT: begin
                // done is only looked at from here on; the accelerator drops it on start
                if (acc_done) begin
                    res_data_d = acc_result;
                    res_tag_d  = job_cnt_q;
                    job_cnt_d  = job_cnt_q + 1'b1;
                    state_d    = S_OUT;
                end
`ifdef DOTSEQ_TIMEOUT_EN
                else if (wdog_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    err_d      = 1'b1;
                    res_data_d = '0;
                    res_tag_d  = job_cnt_q;
                    job_cnt_d  = job_cnt_q + 1'b1;
                    state_d    = S_OUT;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            S_OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    buf_clr = 1'b1;
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    assign res_data = res_data_q;
    assign res_tag  = res_tag_q;
    assign busy     = !((state_q == S_FILL) && (buf_idx == '0));

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed self-checking bench for dot_product_sequencer with a stub accelerator
// (result 9 cycles after start). Define DOTSEQ_TIMEOUT_EN to also exercise the watchdog.
module tb_dot_product_sequencer;

    localparam int unsigned NE = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 64;
    localparam int unsigned TW = 8;
    localparam int unsigned TO = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_a, in_b;
    logic [NE*DW-1:0] acc_a, acc_b;
    logic             acc_start;
    logic             acc_done;
    logic [RW-1:0]    acc_result;
    logic             res_valid;
    logic             res_ready;
    logic [RW-1:0]    res_data;
    logic [TW-1:0]    res_tag;
    logic             busy;
    logic             err_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dot_product_sequencer #(
        .N_ELEM      (NE),
        .DATA_W      (DW),
        .RES_W       (RW),
        .TAG_W       (TW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .acc_a       (acc_a),
        .acc_b       (acc_b),
        .acc_start   (acc_start),
        .acc_done    (acc_done),
        .acc_result  (acc_result),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_tag     (res_tag),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    // Stub accelerator: latches operands on start, clears done, raises done 9 cycles later.
    logic stub_en = 1'b1;
    int   stub_cnt;
    int   start_cnt = 0;

    function automatic logic [RW-1:0] dot(input logic [NE*DW-1:0] a, input logic [NE*DW-1:0] b);
        longint s = 0;
        for (int i = 0; i < NE; i++)
            s += longint'($signed(a[i*DW +: DW])) * longint'($signed(b[i*DW +: DW]));
        return s;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            acc_done   <= 1'b0;
            acc_result <= '0;
            stub_cnt   <= 0;
        end else if (acc_start) begin
            acc_done   <= 1'b0;
            acc_result <= dot(acc_a, acc_b);
            stub_cnt   <= 9;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1 && stub_en) acc_done <= 1'b1;
        end
    end

    always @(posedge clk) if (acc_start) start_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        res_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input int gap);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        for (int n = 0; n < 200; n++) begin
            bit acc = in_ready;
            tick();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) check("beat_accept_bound", 64'(ok), 64'd1);
        repeat (gap) tick();
    endtask

    task automatic wait_res();
        for (int n = 0; n < 200; n++) begin
            if (res_valid) break;
            tick();
        end
        check("res_valid_seen", 64'(res_valid), 64'd1);
    endtask

    int s0;
    int n;

    initial begin
        do_reset();

        // Reset state
        check("rst_in_ready",  64'(in_ready), 64'd1);
        check("rst_acc_start", 64'(acc_start), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data",  res_data, 64'd0);
        check("rst_res_tag",   64'(res_tag), 64'd0);
        check("rst_acc_a_or_b", 64'(|{acc_a, acc_b}), 64'd0);
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_err",       64'(err_timeout), 64'd0);

        // a=1..8, b=1: 36, tag 0, exactly one start after the 8th beat
        s0 = start_cnt;
        for (int i = 1; i <= 7; i++) send(DW'(i), 32'd1, 0);
        check("j1_busy_mid", 64'(busy), 64'd1);
        check("j1_no_early_start", 64'(start_cnt - s0), 64'd0);
        send(32'd8, 32'd1, 0);
        check("j1_start_pulse", 64'(acc_start), 64'd1);
        check("j1_in_ready_start", 64'(in_ready), 64'd0);
        check("j1_acc_a_slot0", 64'(acc_a[31:0]), 64'd1);
        check("j1_acc_a_slot7", 64'(acc_a[255:224]), 64'd8);
        wait_res();
        check("j1_data", res_data, 64'd36);
        check("j1_tag", 64'(res_tag), 64'd0);
        check("j1_one_start", 64'(start_cnt - s0), 64'd1);
        tick();
        check("j1_back_ready", 64'(in_ready), 64'd1);
        check("j1_idle_busy", 64'(busy), 64'd0);
        check("j1_err", 64'(err_timeout), 64'd0);

        // a=i, b=-i: -204; then a=b=0: 0 with tag 1
        do_reset();
        for (int i = 1; i <= 8; i++) send(DW'(i), DW'(-i), 0);
        wait_res();
        check("neg_data", res_data, 64'hFFFF_FFFF_FFFF_FF34);
        check("neg_tag", 64'(res_tag), 64'd0);
        tick();
        for (int i = 0; i < 8; i++) send(32'd0, 32'd0, 0);
        wait_res();
        check("zero_data", res_data, 64'd0);
        check("zero_tag", 64'(res_tag), 64'd1);
        tick();

        // Gapped input: start only after the 8th beat
        do_reset();
        s0 = start_cnt;
        for (int i = 1; i <= 7; i++) send(DW'(i), 32'd1, 1);
        check("gap_no_start", 64'(start_cnt - s0), 64'd0);
        check("gap_still_ready", 64'(in_ready), 64'd1);
        send(32'd8, 32'd1, 0);
        wait_res();
        check("gap_data", res_data, 64'd36);
        check("gap_starts", 64'(start_cnt - s0), 64'd1);
        tick();

        // Back-pressure: result held 20 cycles, extra input ignored
        do_reset();
        res_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(DW'(i), 32'd1, 0);
        wait_res();
        in_valid = 1'b1;
        in_a = 32'd77;
        in_b = 32'd77;
        for (int c = 0; c < 20; c++) begin
            check("hold_vld_rdy", {62'd0, res_valid, in_ready}, 64'd2);
            check("hold_data", res_data, 64'd36);
            tick();
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        check("hold_release_ready", 64'(in_ready), 64'd1);
        check("hold_nothing_taken", 64'(busy), 64'd0);

        // Reset mid-fill discards the partial vector
        do_reset();
        for (int i = 0; i < 5; i++) send(32'd9, 32'd9, 0);
        check("mid_busy", 64'(busy), 64'd1);
        do_reset();
        check("mid_cleared_ops", 64'(|{acc_a, acc_b}), 64'd0);
        check("mid_idle", 64'(busy), 64'd0);
        for (int i = 0; i < 8; i++) send(32'd2, 32'd3, 0);
        wait_res();
        check("mid_data", res_data, 64'd48);
        check("mid_tag", 64'(res_tag), 64'd0);
        tick();

        // Tag counter wraps 255 -> 0
        do_reset();
        for (int j = 0; j < 257; j++) begin
            for (int i = 0; i < 8; i++) send(32'd0, 32'd0, 0);
            wait_res();
            if (j == 255) check("tag_max", 64'(res_tag), 64'd255);
            if (j == 256) check("tag_wrap", 64'(res_tag), 64'd0);
            tick();
        end

`ifdef DOTSEQ_TIMEOUT_EN
        // Watchdog: no done -> abort after TIMEOUT_CYC wait cycles, zero result returned
        do_reset();
        stub_en = 1'b0;
        for (int i = 1; i <= 8; i++) send(DW'(i), 32'd1, 0);
        check("to_start", 64'(acc_start), 64'd1);
        n = 0;
        while (!res_valid && n < 200) begin
            tick();
            n++;
            if (n == TO) check("to_err_before", 64'(err_timeout), 64'd0);
        end
        check("to_latency", 64'(n), 64'(TO + 1));
        check("to_err", 64'(err_timeout), 64'd1);
        check("to_data", res_data, 64'd0);
        check("to_tag", 64'(res_tag), 64'd0);
        tick();
        stub_en = 1'b1;
        for (int i = 1; i <= 8; i++) send(DW'(i), 32'd1, 0);
        wait_res();
        check("to_next_data", res_data, 64'd36);
        check("to_next_tag", 64'(res_tag), 64'd1);
        check("to_sticky", 64'(err_timeout), 64'd1);
        tick();
        do_reset();
        check("to_rst_clears", 64'(err_timeout), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
